// File: rtl/isp_pkg.sv
// Shared definitions for the ISP loader: command bytes, status bytes,
// the loader FSM state encoding and the write-status priority helper.
package isp_pkg;

  localparam logic [7:0] ISP_CMD_WRITE = 8'hA5;
  localparam logic [7:0] ISP_CMD_BOOT  = 8'h5A;
  localparam logic [7:0] ISP_CMD_HOLD  = 8'h3C;

  localparam logic [7:0] ISP_ST_OK      = 8'h00;
  localparam logic [7:0] ISP_ST_BAD_CMD = 8'hE1;
  localparam logic [7:0] ISP_ST_OVERRUN = 8'hE2;
  localparam logic [7:0] ISP_ST_BUS_ERR = 8'hE3;
  localparam logic [7:0] ISP_ST_TIMEOUT = 8'hE4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_RESP  = 3'd5
  } isp_state_e;

  // Overrun outranks a bus error when both happened during one WRITE.
  function automatic logic [7:0] isp_write_status(input logic overrun, input logic bus_err);
    if (overrun)      return ISP_ST_OVERRUN;
    else if (bus_err) return ISP_ST_BUS_ERR;
    else              return ISP_ST_OK;
  endfunction

endpackage

// File: rtl/isp_word_packer.sv
// Packs a stream of payload bytes into 32-bit words with byte-lane selects.
// One assembly register collects bytes; a completed word moves into the
// write register, which is what the Wishbone master presents on the bus.
// A word completing while the write register is still busy is dropped and
// flagged as an overrun.
module isp_word_packer import isp_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic                  byte_dv_i,
  input  logic [7:0]            byte_i,
  input  logic                  last_i,
  input  logic                  wr_done_i,
  output logic                  wr_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_adr_o,
  output logic [31:0]           wr_dat_o,
  output logic [3:0]            wr_sel_o,
  output logic                  overrun_o
);

  localparam int WI_W = ADDR_WIDTH - 2;
  localparam logic [WI_W-1:0] WI_ONE = WI_W'(1);

  logic [1:0]      lane;
  logic [WI_W-1:0] word_idx;
  logic [31:0]     asm_dat;
  logic [31:0]     merged_dat;
  logic [3:0]      asm_sel;
  logic [3:0]      merged_sel;
  logic            word_done;
  logic            wr_busy;

  assign word_done = byte_dv_i && ((lane == 2'd3) || last_i);
  // The write register is free again in the cycle its ack/err arrives.
  assign wr_busy   = wr_valid_o && !wr_done_i;

  // Assembly word with the incoming byte merged into its lane.
  always_comb begin
    merged_dat = asm_dat;
    merged_dat[{lane, 3'b000} +: 8] = byte_i;
    merged_sel = asm_sel | (4'b0001 << lane);
  end

  // Lane counter, word index and assembly register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane      <= 2'd0;
      word_idx  <= '0;
      asm_dat   <= '0;
      asm_sel   <= '0;
      overrun_o <= 1'b0;
    end else if (start_i) begin
      lane      <= start_addr_i[1:0];
      word_idx  <= start_addr_i[ADDR_WIDTH-1:2];
      asm_dat   <= '0;
      asm_sel   <= '0;
      overrun_o <= 1'b0;
    end else if (byte_dv_i) begin
      if (word_done) begin
        lane     <= 2'd0;
        word_idx <= word_idx + WI_ONE;
        asm_dat  <= '0;
        asm_sel  <= '0;
        if (wr_busy) overrun_o <= 1'b1;
      end else begin
        lane    <= lane + 2'd1;
        asm_dat <= merged_dat;
        asm_sel <= merged_sel;
      end
    end
  end

  // Write register: loads a completed word when free, clears on retire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_valid_o <= 1'b0;
      wr_adr_o   <= '0;
      wr_dat_o   <= '0;
      wr_sel_o   <= '0;
    end else if (word_done && !wr_busy) begin
      wr_valid_o <= 1'b1;
      wr_adr_o   <= {2'b00, word_idx};
      wr_dat_o   <= merged_dat;
      wr_sel_o   <= merged_sel;
    end else if (wr_done_i) begin
      wr_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/isp_loader.sv
// In-system-programming loader. Decodes WRITE/HOLD/BOOT commands from the
// SPI slave byte stream, writes payload to memory as a Wishbone master and
// controls the core reset. wb_adr_o is a word address.
// Optional build macro: ISP_LOADER_TIMEOUT_EN adds an inter-byte timeout
// that aborts a WRITE with status 0xE4.
//
// Handshakes: rx_dv_i/tx_dv_o are single-cycle strobes with no backpressure.
// Wishbone cyc/stb/we rise with a loaded write register and stay high until
// the cycle in which ack or err is seen; a new word may load in that same
// cycle, in which case the next transfer follows without a gap.
module isp_loader import isp_pkg::*; #(
  parameter int ADDR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int BOOT_HOLD_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  tx_dv_o,
  output logic [7:0]            tx_byte_o,
  output logic                  core_rst_no,
  output logic                  busy_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [2:0]            state_o
);

  isp_state_e state;
  logic [1:0]  cnt;
  logic [31:0] addr_buf;
  logic [7:0]  len_lo;
  logic [15:0] remaining;
  logic        bus_err;
  logic        resp_write;
  logic        pkr_start;
  logic        data_dv;
  logic        last_byte;
  logic        wr_valid;
  logic        wr_done;
  logic        overrun;

  assign data_dv   = (state == ST_DATA) && rx_dv_i;
  assign last_byte = (remaining == 16'd1);
  assign pkr_start = (state == ST_LEN) && rx_dv_i && cnt[0];
  assign wr_done   = wr_valid && (wb_ack_i || wb_err_i);

  assign wb_cyc_o = wr_valid;
  assign wb_stb_o = wr_valid;
  assign wb_we_o  = wr_valid;
  assign busy_o   = (state != ST_IDLE);
  assign state_o  = state;

`ifdef ISP_LOADER_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        timed_out;
  logic        to_hit;
  assign to_hit = (state inside {ST_ADDR, ST_LEN, ST_DATA}) && !rx_dv_i &&
                  (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  isp_word_packer #(.ADDR_WIDTH(ADDR_WIDTH)) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (pkr_start),
    .start_addr_i(addr_buf[ADDR_WIDTH-1:0]),
    .byte_dv_i   (data_dv),
    .byte_i      (rx_byte_i),
    .last_i      (last_byte),
    .wr_done_i   (wr_done),
    .wr_valid_o  (wr_valid),
    .wr_adr_o    (wb_adr_o),
    .wr_dat_o    (wb_dat_o),
    .wr_sel_o    (wb_sel_o),
    .overrun_o   (overrun)
  );

  // Command FSM: header collection, data counting, drain and status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= 2'd0;
      addr_buf    <= '0;
      len_lo      <= '0;
      remaining   <= '0;
      bus_err     <= 1'b0;
      resp_write  <= 1'b0;
      tx_dv_o     <= 1'b0;
      tx_byte_o   <= '0;
      core_rst_no <= (BOOT_HOLD_RESET == 0);
`ifdef ISP_LOADER_TIMEOUT_EN
      to_cnt      <= '0;
      timed_out   <= 1'b0;
`endif
    end else begin
      tx_dv_o <= 1'b0;
      if (wr_valid && wb_err_i) bus_err <= 1'b1;
`ifdef ISP_LOADER_TIMEOUT_EN
      if (state inside {ST_ADDR, ST_LEN, ST_DATA})
        to_cnt <= rx_dv_i ? 32'd0 : to_cnt + 32'd1;
      else
        to_cnt <= 32'd0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_dv_i) begin
            case (rx_byte_i)
              ISP_CMD_WRITE: begin
                state <= ST_ADDR;
                cnt   <= 2'd0;
              end
              ISP_CMD_HOLD: begin
                core_rst_no <= 1'b0;
                state       <= ST_RESP;
              end
              ISP_CMD_BOOT: begin
                core_rst_no <= 1'b1;
                state       <= ST_RESP;
              end
              default: begin
                tx_dv_o   <= 1'b1;
                tx_byte_o <= ISP_ST_BAD_CMD;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (rx_dv_i) begin
            addr_buf <= {rx_byte_i, addr_buf[31:8]};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_dv_i) begin
            if (!cnt[0]) begin
              len_lo <= rx_byte_i;
              cnt    <= 2'd1;
            end else begin
              cnt        <= 2'd0;
              remaining  <= {rx_byte_i, len_lo};
              bus_err    <= 1'b0;
              resp_write <= 1'b1;
              state      <= ({rx_byte_i, len_lo} == 16'd0) ? ST_RESP : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_dv_i) begin
            remaining <= remaining - 16'd1;
            if (last_byte) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!wr_valid || wr_done) state <= ST_RESP;
        end
        ST_RESP: begin
          tx_dv_o    <= 1'b1;
          resp_write <= 1'b0;
          state      <= ST_IDLE;
`ifdef ISP_LOADER_TIMEOUT_EN
          timed_out  <= 1'b0;
          if (timed_out) tx_byte_o <= ISP_ST_TIMEOUT;
          else
`endif
          if (resp_write) tx_byte_o <= isp_write_status(overrun, bus_err);
          else            tx_byte_o <= ISP_ST_OK;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef ISP_LOADER_TIMEOUT_EN
      if (to_hit) begin
        state     <= ST_DRAIN;
        timed_out <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_isp_loader.sv
// Bench for isp_loader: directed protocol steps plus randomized WRITEs,
// a Wishbone slave with programmable ack delay / error injection, and a
// byte-address reference model for the expected memory writes.
module tb_isp_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        core_rst_n;
  logic        busy;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        ack, err;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  logic [31:0] exp_sel_q[$];
  logic [31:0] log_adr_q[$];
  logic [31:0] log_dat_q[$];
  logic [31:0] log_sel_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  payload[$];

  int ack_delay   = 0;
  int err_on_xfer = -1;
  int xfer_cnt    = 0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  isp_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_dv_i    (rx_dv),
    .rx_byte_i  (rx_byte),
    .tx_dv_o    (tx_dv),
    .tx_byte_o  (tx_byte),
    .core_rst_no(core_rst_n),
    .busy_o     (busy),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (we),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat),
    .wb_sel_o   (sel),
    .wb_ack_i   (ack),
    .wb_err_i   (err),
    .state_o    (state)
  );

  // Wishbone slave: answers after ack_delay waiting cycles, logs each transfer.
  initial begin : wb_slave
    int wait_cnt;
    wait_cnt = 0;
    ack = 1'b0;
    err = 1'b0;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        ack = 1'b0;
        err = 1'b0;
        wait_cnt = 0;
      end else if (cyc && stb && we) begin
        if (wait_cnt >= ack_delay) begin
          log_adr_q.push_back(adr);
          log_dat_q.push_back(dat);
          log_sel_q.push_back({28'd0, sel});
          if (xfer_cnt == err_on_xfer) err = 1'b1;
          else                         ack = 1'b1;
          xfer_cnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Status byte monitor
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) tx_q.push_back(tx_byte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver: call at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Reference: every payload byte i lands at byte address a+i; consecutive
  // bytes sharing a 32-bit word form one write to that word.
  task automatic model_write(input logic [31:0] a, input int n);
    logic [31:0] ba, w, cw, cd;
    logic [3:0]  cs;
    cw = '0; cd = '0; cs = '0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      w  = {2'b00, ba[31:2]};
      if (i == 0 || w != cw) begin
        if (i != 0) begin
          exp_adr_q.push_back(cw); exp_dat_q.push_back(cd); exp_sel_q.push_back({28'd0, cs});
        end
        cw = w; cd = '0; cs = '0;
      end
      cd[{ba[1:0], 3'b000} +: 8] = payload[i];
      cs[ba[1:0]] = 1'b1;
    end
    if (n > 0) begin
      exp_adr_q.push_back(cw); exp_dat_q.push_back(cd); exp_sel_q.push_back({28'd0, cs});
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int n, input int gmin, input int gmax);
    logic [15:0] len;
    len = 16'(n);
    while (payload.size() < n) payload.push_back(8'($urandom_range(0, 255)));
    model_write(a, n);
    send_byte(8'hA5, $urandom_range(gmin, gmax));
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8], $urandom_range(gmin, gmax));
    send_byte(len[7:0], $urandom_range(gmin, gmax));
    send_byte(len[15:8], $urandom_range(gmin, gmax));
    for (int i = 0; i < n; i++) send_byte(payload[i], $urandom_range(gmin, gmax));
    payload.delete();
  endtask

  task automatic wait_status(input logic [7:0] expv, input string tag);
    int t;
    t = 0;
    while (tx_q.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_seen"}, 32'(tx_q.size() != 0), 32'd1);
    if (tx_q.size() != 0) chk({tag, "_status"}, {24'd0, tx_q.pop_front()}, {24'd0, expv});
    repeat (3) @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(tx_q.size()), 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    logic [31:0] m, ea, ed, es;
    chk({tag, "_nwrites"}, 32'(log_adr_q.size()), 32'(exp_adr_q.size()));
    while (exp_adr_q.size() > 0 && log_adr_q.size() > 0) begin
      ea = exp_adr_q.pop_front();
      ed = exp_dat_q.pop_front();
      es = exp_sel_q.pop_front();
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{es[b]}};
      chk({tag, "_adr"}, log_adr_q.pop_front(), ea);
      chk({tag, "_sel"}, log_sel_q.pop_front(), es);
      chk({tag, "_dat"}, log_dat_q.pop_front() & m, ed);
    end
    exp_adr_q.delete(); exp_dat_q.delete(); exp_sel_q.delete();
    log_adr_q.delete(); log_dat_q.delete(); log_sel_q.delete();
  endtask

  initial begin
    logic [31:0] ra;
    int rn;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_cyc", {29'd0, cyc, stb, we}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_core", {31'd0, core_rst_n}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // HOLD / BOOT
    send_byte(8'h3C, 0); wait_status(8'h00, "hold1"); chk("hold1_core", {31'd0, core_rst_n}, 32'd0);
    send_byte(8'h5A, 0); wait_status(8'h00, "boot1"); chk("boot1_core", {31'd0, core_rst_n}, 32'd1);
    send_byte(8'h3C, 2); wait_status(8'h00, "hold2"); chk("hold2_core", {31'd0, core_rst_n}, 32'd0);
    send_byte(8'h5A, 1); wait_status(8'h00, "boot2"); chk("boot2_core", {31'd0, core_rst_n}, 32'd1);

    // Unknown command
    send_byte(8'h77, 0); wait_status(8'hE1, "badcmd");

    // Aligned write
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_write(32'h0, 8, 0, 0);
    wait_status(8'h00, "aligned");
    check_writes("aligned");
    chk("aligned_core_kept", {31'd0, core_rst_n}, 32'd1);

    // Unaligned write
    payload = '{8'hAA, 8'hBB};
    do_write(32'h3, 2, 0, 1);
    wait_status(8'h00, "unaligned");
    check_writes("unaligned");

    // Zero-length write
    do_write(32'h40, 0, 0, 0);
    wait_status(8'h00, "len0");
    check_writes("len0");

    // Ack retires a word in the same cycle the last byte completes the next
    ack_delay = 0;
    do_write(32'h0, 5, 0, 0);
    wait_status(8'h00, "same_cycle");
    check_writes("same_cycle");

    // Bus error on first of two words
    err_on_xfer = xfer_cnt;
    do_write(32'h100, 8, 1, 3);
    wait_status(8'hE3, "buserr");
    check_writes("buserr");
    err_on_xfer = -1;

    // Overrun: slow slave while bytes stream every cycle
    ack_delay = 10;
    do_write(32'h0, 12, 0, 0);
    wait_status(8'hE2, "overrun");
    chk("overrun_state", {29'd0, state}, 32'd0);
    repeat (15) @(negedge clk);
    exp_adr_q.delete(); exp_dat_q.delete(); exp_sel_q.delete();
    log_adr_q.delete(); log_dat_q.delete(); log_sel_q.delete();
    ack_delay = 0;

    // Randomized writes, bytes spaced so the bus always keeps up
    for (int it = 0; it < 6; it++) begin
      ra = (it == 0) ? 32'hFFFF_FFFD : $urandom;
      rn = $urandom_range(1, 12);
      ack_delay = $urandom_range(0, 2);
      do_write(ra, rn, 4, 6);
      wait_status(8'h00, "rand");
      check_writes("rand");
    end
    ack_delay = 0;

    // Reset in the middle of a pending Wishbone write
    ack_delay = 10;
    send_byte(8'hA5, 0);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 0);
    chk("midrst_cyc_before", {31'd0, cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", {29'd0, cyc, stb, we}, 32'd0);
    chk("midrst_adr", adr, 32'd0);
    chk("midrst_sel", {28'd0, sel}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_core", {31'd0, core_rst_n}, 32'd0);
    chk("midrst_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    log_adr_q.delete(); log_dat_q.delete(); log_sel_q.delete();
    tx_q.delete();
    send_byte(8'h5A, 0);
    wait_status(8'h00, "post_rst_boot");
    chk("post_rst_core", {31'd0, core_rst_n}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
